// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and constants for the
// multi-cycle left-shift unit.
package shift_seq_ctrl_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic {
    SSC_IDLE = 1'b0,
    SSC_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Start/busy/done handshake bundle
// for the shift sequencer.
interface shift_seq_ctrl_if
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] X;
  logic [31:0]      Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Z;

  modport master (
    output start, X, Y,
    input  busy, done, Z
  );

  modport slave (
    input  start, X, Y,
    output busy, done, Z
  );

endinterface

// File: rtl/shift_left_1bit.sv
// Bit-slice cell: bit I of X << Y,
// with an untruncated 32-bit Y.
module shift_left_1bit
  import shift_seq_ctrl_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] X,
  input  logic [31:0]          Y,
  input  logic [31:0]          I,
  output logic                 Z
);

  logic [31:0] src;
  logic        hit;

  assign src = I - Y;

  // Source bit exists only when Y <= I
  // and the index lands inside X.
  assign hit = (Y <= I) &&
               (src < 32'(ALU_WIDTH));

  assign Z = hit ? X[src[4:0]] : 1'b0;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences LANES bit-slice cells over
// the word to build X << Y, one slice/cycle.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int LANES = 1
)
(
  input  logic         clk,
  input  logic         rst,
  shift_seq_ctrl_if.slave bus
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST =
    IW'(WIDTH - LANES);
  localparam logic [IW-1:0] STEP =
    IW'(LANES);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] xq;
  logic [31:0]      yq;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] z;
  logic             busy;
  logic             done;
  logic [LANES-1:0] lane_z;
  logic [31:0]      xe;

  assign xe = 32'(xq);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    shift_left_1bit u_cell (
      .X (xe),
      .Y (yq),
      .I (32'(idx) + 32'(l)),
      .Z (lane_z[l])
    );
  end

  // Merge the current slice into the
  // accumulator image.
  always_comb begin
    acc_nxt = acc;
    acc_nxt[idx +: LANES] = lane_z;
  end

  // FSM, slice counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SSC_IDLE;
      idx   <= '0;
      xq    <= '0;
      yq    <= '0;
      acc   <= '0;
      z     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        SSC_IDLE: begin
          if (bus.start) begin
            xq    <= bus.X;
            yq    <= bus.Y;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= SSC_RUN;
          end
        end
        SSC_RUN: begin
          acc <= acc_nxt;
          idx <= idx + STEP;
          if (idx == LAST) begin
            z     <= acc_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= SSC_IDLE;
          end
        end
        default: state <= SSC_IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.Z    = z;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: vector table, corner
// sequences and random ops vs a shift model.
module tb_shift_seq_ctrl;

  parameter int LANES = 1;
  localparam int WIDTH = 32;
  localparam int N = WIDTH / LANES;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  shift_seq_ctrl #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] model(
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint unsigned w;
    if (y >= 32'(WIDTH)) return '0;
    w = longint'(x) * (64'd1 << y);
    return w[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic run_op(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] z,
    output int lat,
    output int bcnt
  );
    bus.start = 1'b1;
    bus.X = x;
    bus.Y = y;
    tick();
    bus.start = 1'b0;
    bus.X = $urandom;
    bus.Y = $urandom;
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      tick();
      lat++;
    end
    z = bus.Z;
  endtask

  initial begin
    logic [31:0] z;
    logic [31:0] z1;
    logic [31:0] z2;
    logic [31:0] rx;
    logic [31:0] ry;
    int lat;
    int bcnt;
    int pulses;
    int k;
    int cyc;
    int nd;
    int d1;
    int d2;

    checks = 0;
    failures = 0;
    vecs[0] = '{32'hA, 32'd0, 32'hA};
    vecs[1] = '{32'hA, 32'd1, 32'h14};
    vecs[2] = '{32'hA, 32'd35, 32'h0};
    vecs[3] = '{32'h8000_0001, 32'd31,
                32'h8000_0000};
    vecs[4] = '{32'h8000_0001, 32'd32, 32'h0};
    vecs[5] = '{32'hA, 32'd2, 32'h28};
    vecs[6] = '{32'h1, 32'd4, 32'h10};
    vecs[7] = '{32'h1, 32'd8, 32'h100};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0};
    vecs[9] = '{32'hFFFF_FFFF, 32'd16,
                32'hFFFF_0000};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_z", bus.Z, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].x, vecs[i].y, z, lat, bcnt);
      chk($sformatf("vec%0d_z", i),
          z, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i),
          32'(lat), 32'(N));
      chk($sformatf("vec%0d_busy", i),
          32'(bcnt), 32'(N));
      chk($sformatf("vec%0d_busy_end", i),
          32'(bus.busy), 32'd0);
      tick();
      chk($sformatf("vec%0d_done_1cyc", i),
          32'(bus.done), 32'd0);
    end

    // reset during RUN
    bus.start = 1'b1;
    bus.X = 32'hA;
    bus.Y = 32'd0;
    tick();
    bus.start = 1'b0;
    k = (N - 1 < 10) ? N - 1 : 10;
    for (int i = 0; i < k; i++) tick();
    chk("midrst_busy_before",
        32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_z", bus.Z, 32'h0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);

    // start while busy is ignored
    bus.start = 1'b1;
    bus.X = 32'hA;
    bus.Y = 32'd2;
    tick();
    bus.X = 32'hFFFF_FFFF;
    bus.Y = 32'd0;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    z = 32'hDEAD_BEEF;
    if (bus.done) begin
      pulses++;
      z = bus.Z;
    end
    for (int i = 0; i < N + 8; i++) begin
      tick();
      if (bus.done) begin
        pulses++;
        z = bus.Z;
      end
    end
    chk("ign_z", z, 32'h28);
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_zhold", bus.Z, 32'h28);

    // back-to-back with start held high
    bus.start = 1'b1;
    bus.X = 32'h1;
    bus.Y = 32'd4;
    tick();
    bus.Y = 32'd8;
    cyc = 0;
    nd = 0;
    d1 = 0;
    d2 = 0;
    z1 = '0;
    z2 = '0;
    while (nd < 2 && cyc < 500) begin
      tick();
      cyc++;
      if (bus.done) begin
        if (nd == 0) begin
          d1 = cyc;
          z1 = bus.Z;
        end else begin
          d2 = cyc;
          z2 = bus.Z;
          bus.start = 1'b0;
        end
        nd++;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(nd), 32'd2);
    chk("b2b_first", 32'(d1), 32'(N));
    chk("b2b_space", 32'(d2 - d1), 32'(N + 1));
    chk("b2b_z1", z1, 32'h10);
    chk("b2b_z2", z2, 32'h100);
    tick();
    chk("b2b_idle", 32'(bus.busy), 32'd0);
    chk("b2b_done_low", 32'(bus.done), 32'd0);

    // random ops vs model
    for (int i = 0; i < 1000; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 3) == 0)
        ry = $urandom;
      else
        ry = $urandom_range(0, 40);
      run_op(rx, ry, z, lat, bcnt);
      chk($sformatf("rnd%0d x=%h y=%0d", i, rx, ry),
          z, model(rx, ry));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
